// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings for the memory data bus: access types and arbiter state codes.
package mem_bus_arbiter_pkg;

  localparam int MEM_ACCESS_W = 2;
  localparam logic [MEM_ACCESS_W-1:0] ACC_NONE = 2'd0;
  localparam logic [MEM_ACCESS_W-1:0] ACC_R    = 2'd1;
  localparam logic [MEM_ACCESS_W-1:0] ACC_W    = 2'd2;
  localparam logic [MEM_ACCESS_W-1:0] ACC_X    = 2'd3;

  localparam int ARB_STATE_W = 2;
  localparam logic [ARB_STATE_W-1:0] ARB_S_ARB  = 2'd0;
  localparam logic [ARB_STATE_W-1:0] ARB_S_GNT0 = 2'd1;
  localparam logic [ARB_STATE_W-1:0] ARB_S_GNT1 = 2'd2;

  localparam int LOCK_CNT_W = 8;

endpackage

// File: rtl/mem_bus_arbiter_arb_pick.sv
// Combinational winner selection between two requesters.
module arb_pick #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic req0,
  input  logic req1,
  input  logic rr_last,
  output logic valid,
  output logic pick
);

  always_comb begin
    valid = req0 | req1;
    if (req0 && req1) begin
      // on a tie round-robin favours whichever master was not served last
      pick = FIXED_PRIO ? 1'b0 : ~rr_last;
    end else begin
      pick = req1;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master, one-slave memory bus arbiter with lock support and lock timeout.
//  state | meaning
//  ARB   | no grant, choose next master
//  GNT0  | master 0 owns the slave bus
//  GNT1  | master 1 owns the slave bus
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0,
  parameter int LOCK_MAX   = 64
) (
  input  logic                    clk,
  input  logic                    res,
  input  logic [31:0]             m0_addr,
  input  logic [31:0]             m0_dataOut,
  input  logic [MEM_ACCESS_W-1:0] m0_accessType,
  input  logic                    m0_lock,
  output logic [31:0]             m0_dataIn,
  output logic                    m0_ready,
  input  logic [31:0]             m1_addr,
  input  logic [31:0]             m1_dataOut,
  input  logic [MEM_ACCESS_W-1:0] m1_accessType,
  input  logic                    m1_lock,
  output logic [31:0]             m1_dataIn,
  output logic                    m1_ready,
  output logic [31:0]             s_addr,
  output logic [31:0]             s_dataOut,
  output logic [MEM_ACCESS_W-1:0] s_accessType,
  input  logic [31:0]             s_dataIn,
  input  logic                    s_ready,
  output logic                    lock_err
);

  localparam logic [LOCK_CNT_W-1:0] LOCK_LAST = LOCK_CNT_W'(LOCK_MAX - 1);
  localparam logic [LOCK_CNT_W-1:0] CNT_SAT   = '1;

  logic [ARB_STATE_W-1:0] state, state_nxt;
  logic                   rr_last, rr_nxt;
  logic [LOCK_CNT_W-1:0]  lock_cnt, cnt_nxt;
  logic                   pick_valid, pick;
  logic                   gnt0, gnt1, granted;
  logic [MEM_ACCESS_W-1:0] g_acc;
  logic                   g_lock, g_idle, timeout;

  arb_pick #(.FIXED_PRIO(FIXED_PRIO)) u_pick (
    .req0    (m0_accessType != ACC_NONE),
    .req1    (m1_accessType != ACC_NONE),
    .rr_last (rr_last),
    .valid   (pick_valid),
    .pick    (pick)
  );

  always_comb begin
    gnt0    = (state == ARB_S_GNT0);
    gnt1    = (state == ARB_S_GNT1);
    granted = gnt0 | gnt1;
    g_acc   = gnt1 ? m1_accessType : m0_accessType;
    g_lock  = gnt1 ? m1_lock : m0_lock;
    g_idle  = (g_acc == ACC_NONE);
    // only an idle locked grant can time out, never one with an access in flight
    timeout = granted && g_lock && g_idle && !s_ready && (lock_cnt >= LOCK_LAST);
  end

  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_last;
    cnt_nxt   = lock_cnt;
    case (state)
      ARB_S_ARB: begin
        cnt_nxt = '0;
        if (pick_valid) state_nxt = pick ? ARB_S_GNT1 : ARB_S_GNT0;
      end
      ARB_S_GNT0, ARB_S_GNT1: begin
        if (s_ready) begin
          cnt_nxt = '0;
          if (!g_lock) begin
            state_nxt = ARB_S_ARB;
            rr_nxt    = gnt1;
          end
        end else if (g_idle && !g_lock) begin
          state_nxt = ARB_S_ARB;
          cnt_nxt   = '0;
        end else if (timeout) begin
          state_nxt = ARB_S_ARB;
          rr_nxt    = gnt1;
          cnt_nxt   = '0;
        end else if (lock_cnt != CNT_SAT) begin
          cnt_nxt = lock_cnt + 1'b1;
        end
      end
      default: state_nxt = ARB_S_ARB;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state    <= ARB_S_ARB;
      rr_last  <= 1'b1;
      lock_cnt <= '0;
      lock_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      rr_last  <= rr_nxt;
      lock_cnt <= cnt_nxt;
      lock_err <= timeout;
    end
  end

  always_comb begin
    s_addr       = '0;
    s_dataOut    = '0;
    s_accessType = ACC_NONE;
    if (gnt0) begin
      s_addr       = m0_addr;
      s_dataOut    = m0_dataOut;
      s_accessType = m0_accessType;
    end else if (gnt1) begin
      s_addr       = m1_addr;
      s_dataOut    = m1_dataOut;
      s_accessType = m1_accessType;
    end
    m0_ready  = gnt0 & s_ready;
    m1_ready  = gnt1 & s_ready;
    m0_dataIn = gnt0 ? s_dataIn : '0;
    m1_dataIn = gnt1 ? s_dataIn : '0;
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench: round-robin/lock-timeout instance plus a fixed-priority instance on shared inputs.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  logic clk = 1'b0;
  logic res = 1'b0;
  logic [31:0] m0_addr, m0_dataOut, m1_addr, m1_dataOut, s_dataIn;
  logic [1:0]  m0_accessType, m1_accessType;
  logic        m0_lock, m1_lock, s_ready;

  logic [31:0] m0_dataIn, m1_dataIn, s_addr, s_dataOut;
  logic        m0_ready, m1_ready, lock_err;
  logic [1:0]  s_accessType;

  logic [31:0] fp_m0_dataIn, fp_m1_dataIn, fp_s_addr, fp_s_dataOut;
  logic        fp_m0_ready, fp_m1_ready, fp_lock_err;
  logic [1:0]  fp_s_accessType;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.FIXED_PRIO(1'b0), .LOCK_MAX(4)) dut (
    .clk(clk), .res(res),
    .m0_addr(m0_addr), .m0_dataOut(m0_dataOut), .m0_accessType(m0_accessType), .m0_lock(m0_lock),
    .m0_dataIn(m0_dataIn), .m0_ready(m0_ready),
    .m1_addr(m1_addr), .m1_dataOut(m1_dataOut), .m1_accessType(m1_accessType), .m1_lock(m1_lock),
    .m1_dataIn(m1_dataIn), .m1_ready(m1_ready),
    .s_addr(s_addr), .s_dataOut(s_dataOut), .s_accessType(s_accessType),
    .s_dataIn(s_dataIn), .s_ready(s_ready), .lock_err(lock_err)
  );

  mem_bus_arbiter #(.FIXED_PRIO(1'b1), .LOCK_MAX(4)) dut_fp (
    .clk(clk), .res(res),
    .m0_addr(m0_addr), .m0_dataOut(m0_dataOut), .m0_accessType(m0_accessType), .m0_lock(m0_lock),
    .m0_dataIn(fp_m0_dataIn), .m0_ready(fp_m0_ready),
    .m1_addr(m1_addr), .m1_dataOut(m1_dataOut), .m1_accessType(m1_accessType), .m1_lock(m1_lock),
    .m1_dataIn(fp_m1_dataIn), .m1_ready(fp_m1_ready),
    .s_addr(fp_s_addr), .s_dataOut(fp_s_dataOut), .s_accessType(fp_s_accessType),
    .s_dataIn(s_dataIn), .s_ready(s_ready), .lock_err(fp_lock_err)
  );

  // advance to just after the next rising edge; stimulus for the new cycle is applied here
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    m0_addr = 32'h0; m0_dataOut = 32'h0; m0_accessType = ACC_NONE; m0_lock = 1'b0;
    m1_addr = 32'h0; m1_dataOut = 32'h0; m1_accessType = ACC_NONE; m1_lock = 1'b0;
    s_dataIn = 32'hDEAD_BEEF; s_ready = 1'b1;
    res = 1'b0;
    cyc(); cyc(); #1;
    n_tests++; if (s_accessType !== ACC_NONE) begin n_fail++; $display("FAIL rst_type: got %0d want %0d", s_accessType, ACC_NONE); end
    n_tests++; if (s_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", s_addr); end
    n_tests++; if ({m0_ready, m1_ready, lock_err} !== 3'b000) begin n_fail++; $display("FAIL rst_ready: got %b want 000", {m0_ready, m1_ready, lock_err}); end
    n_tests++; if (m0_dataIn !== 32'h0) begin n_fail++; $display("FAIL rst_datain: got %h want 0", m0_dataIn); end
    s_ready = 1'b0;
    cyc(); res = 1'b1;
    // request, then pull reset while granted and the slave is completing
    m0_addr = 32'h80; m0_accessType = ACC_R;
    cyc(); #1;
    n_tests++; if (s_accessType !== ACC_R) begin n_fail++; $display("FAIL rst_gnt_type: got %0d want %0d", s_accessType, ACC_R); end
    s_ready = 1'b1; #1;
    n_tests++; if (m0_ready !== 1'b1) begin n_fail++; $display("FAIL rst_gnt_ready: got %b want 1", m0_ready); end
    res = 1'b0; #1;
    n_tests++; if (s_accessType !== ACC_NONE) begin n_fail++; $display("FAIL rst_async_type: got %0d want %0d", s_accessType, ACC_NONE); end
    n_tests++; if (m0_ready !== 1'b0) begin n_fail++; $display("FAIL rst_async_ready: got %b want 0", m0_ready); end
    s_ready = 1'b0; m0_accessType = ACC_NONE; m0_addr = 32'h0;
    cyc(); res = 1'b1;
  endtask

  task automatic test_two_masters();
    m0_addr = 32'h100; m0_dataOut = 32'h0; m0_accessType = ACC_R;
    m1_addr = 32'h200; m1_dataOut = 32'hAAAA_5555; m1_accessType = ACC_W;
    #1;
    n_tests++; if (s_accessType !== ACC_NONE) begin n_fail++; $display("FAIL t2_arb_idle: got %0d want %0d", s_accessType, ACC_NONE); end
    cyc(); #1;
    n_tests++; if (s_addr !== 32'h100) begin n_fail++; $display("FAIL t2_first_addr: got %h want %h", s_addr, 32'h100); end
    n_tests++; if (fp_s_addr !== 32'h100) begin n_fail++; $display("FAIL t2_fp_first_addr: got %h want %h", fp_s_addr, 32'h100); end
    n_tests++; if ({m0_ready, m1_ready} !== 2'b00) begin n_fail++; $display("FAIL t2_no_ready: got %b want 00", {m0_ready, m1_ready}); end
    cyc(); s_ready = 1'b1; s_dataIn = 32'h0000_0055; #1;
    n_tests++; if ({m0_ready, m1_ready} !== 2'b10) begin n_fail++; $display("FAIL t2_m0_ready: got %b want 10", {m0_ready, m1_ready}); end
    n_tests++; if (m0_dataIn !== 32'h55 || m1_dataIn !== 32'h0) begin n_fail++; $display("FAIL t2_m0_data: got %h/%h want 55/0", m0_dataIn, m1_dataIn); end
    cyc(); m0_accessType = ACC_NONE; #1;
    n_tests++; if (s_accessType !== ACC_NONE || s_addr !== 32'h0) begin n_fail++; $display("FAIL t2_mid_arb: got %0d/%h want 0/0", s_accessType, s_addr); end
    n_tests++; if (m1_ready !== 1'b0) begin n_fail++; $display("FAIL t2_arb_ready_ignored: got %b want 0", m1_ready); end
    cyc(); s_ready = 1'b0; #1;
    n_tests++; if (s_addr !== 32'h200 || s_accessType !== ACC_W) begin n_fail++; $display("FAIL t2_second: got %h/%0d want 200/%0d", s_addr, s_accessType, ACC_W); end
    n_tests++; if (s_dataOut !== 32'hAAAA_5555) begin n_fail++; $display("FAIL t2_wdata: got %h want aaaa5555", s_dataOut); end
    s_ready = 1'b1; #1;
    n_tests++; if ({m0_ready, m1_ready} !== 2'b01) begin n_fail++; $display("FAIL t2_m1_ready: got %b want 01", {m0_ready, m1_ready}); end
    cyc(); s_ready = 1'b0; m1_accessType = ACC_NONE;
  endtask

  task automatic test_rmw_lock();
    m0_addr = 32'h104; m0_accessType = ACC_R; m0_lock = 1'b1;
    m1_addr = 32'h300; m1_accessType = ACC_W;
    cyc(); #1;
    n_tests++; if (s_addr !== 32'h104 || s_accessType !== ACC_R) begin n_fail++; $display("FAIL t3_read: got %h/%0d want 104/%0d", s_addr, s_accessType, ACC_R); end
    s_ready = 1'b1; #1;
    n_tests++; if (m0_ready !== 1'b1) begin n_fail++; $display("FAIL t3_read_ready: got %b want 1", m0_ready); end
    cyc(); s_ready = 1'b0; m0_accessType = ACC_W; m0_dataOut = 32'h1122_3344; m0_lock = 1'b0; #1;
    n_tests++; if (s_accessType !== ACC_W || s_addr !== 32'h104) begin n_fail++; $display("FAIL t3_write_direct: got %0d/%h want %0d/104", s_accessType, s_addr, ACC_W); end
    n_tests++; if (s_dataOut !== 32'h1122_3344) begin n_fail++; $display("FAIL t3_wdata: got %h want 11223344", s_dataOut); end
    s_ready = 1'b1; #1;
    n_tests++; if ({m0_ready, m1_ready} !== 2'b10) begin n_fail++; $display("FAIL t3_write_ready: got %b want 10", {m0_ready, m1_ready}); end
    cyc(); s_ready = 1'b0; m0_accessType = ACC_NONE; #1;
    n_tests++; if (s_accessType !== ACC_NONE) begin n_fail++; $display("FAIL t3_arb_after_w: got %0d want 0", s_accessType); end
    cyc(); #1;
    n_tests++; if (s_addr !== 32'h300) begin n_fail++; $display("FAIL t3_m1_grant: got %h want 300", s_addr); end
    s_ready = 1'b1; #1;
    n_tests++; if (m1_ready !== 1'b1) begin n_fail++; $display("FAIL t3_m1_ready: got %b want 1", m1_ready); end
    cyc(); s_ready = 1'b0; m1_accessType = ACC_NONE;
  endtask

  task automatic test_lock_timeout();
    m0_addr = 32'h400; m0_accessType = ACC_R; m0_lock = 1'b1;
    m1_addr = 32'h500; m1_accessType = ACC_R;
    cyc(); s_ready = 1'b1; #1;
    n_tests++; if (s_addr !== 32'h400 || m0_ready !== 1'b1) begin n_fail++; $display("FAIL t4_first: got %h/%b want 400/1", s_addr, m0_ready); end
    cyc(); s_ready = 1'b0; m0_accessType = ACC_NONE;
    for (int i = 1; i <= 4; i++) begin
      #1;
      n_tests++; if (s_addr !== 32'h400 || lock_err !== 1'b0) begin n_fail++; $display("FAIL t4_hold%0d: got %h/%b want 400/0", i, s_addr, lock_err); end
      cyc();
    end
    #1;
    n_tests++; if (lock_err !== 1'b1 || s_addr !== 32'h0) begin n_fail++; $display("FAIL t4_timeout: got %b/%h want 1/0", lock_err, s_addr); end
    cyc(); #1;
    n_tests++; if (lock_err !== 1'b0) begin n_fail++; $display("FAIL t4_pulse_len: got %b want 0", lock_err); end
    n_tests++; if (s_addr !== 32'h500) begin n_fail++; $display("FAIL t4_m1_next: got %h want 500", s_addr); end
    s_ready = 1'b1; #1;
    cyc(); s_ready = 1'b0; m1_accessType = ACC_NONE; m0_lock = 1'b0;
  endtask

  task automatic test_abort();
    m1_addr = 32'h600; m1_accessType = ACC_W;
    cyc(); #1;
    n_tests++; if (s_accessType !== ACC_W || s_addr !== 32'h600) begin n_fail++; $display("FAIL t6_grant: got %0d/%h want %0d/600", s_accessType, s_addr, ACC_W); end
    cyc(); m1_accessType = ACC_NONE; #1;
    n_tests++; if (s_accessType !== ACC_NONE || m1_ready !== 1'b0) begin n_fail++; $display("FAIL t6_abort_now: got %0d/%b want 0/0", s_accessType, m1_ready); end
    cyc(); #1;
    n_tests++; if (s_addr !== 32'h0) begin n_fail++; $display("FAIL t6_arb_next: got %h want 0", s_addr); end
    cyc(); #1;
    n_tests++; if (s_addr !== 32'h0) begin n_fail++; $display("FAIL t6_stay_arb: got %h want 0", s_addr); end
  endtask

  task automatic test_back_to_back_prio();
    logic [31:0] rr_exp [3];
    rr_exp[0] = 32'h700; rr_exp[1] = 32'h800; rr_exp[2] = 32'h700;
    m0_addr = 32'h700; m0_accessType = ACC_R;
    m1_addr = 32'h800; m1_accessType = ACC_R;
    for (int r = 0; r < 3; r++) begin
      cyc(); s_ready = 1'b1; #1;
      n_tests++; if (fp_s_addr !== 32'h700 || fp_m1_ready !== 1'b0) begin n_fail++; $display("FAIL t5_fp_grant%0d: got %h/%b want 700/0", r, fp_s_addr, fp_m1_ready); end
      n_tests++; if (s_addr !== rr_exp[r]) begin n_fail++; $display("FAIL t5_rr_grant%0d: got %h want %h", r, s_addr, rr_exp[r]); end
      cyc(); s_ready = 1'b0; #1;
      n_tests++; if (fp_s_accessType !== ACC_NONE || fp_m1_ready !== 1'b0) begin n_fail++; $display("FAIL t5_fp_arb%0d: got %0d/%b want 0/0", r, fp_s_accessType, fp_m1_ready); end
    end
    m0_accessType = ACC_NONE; m1_accessType = ACC_NONE;
  endtask

  initial begin
    test_reset();
    test_two_masters();
    test_rmw_lock();
    test_lock_timeout();
    test_abort();
    test_back_to_back_prio();
    cyc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
